// File: rtl/mul_div_unit_if.sv
// Bus between the processor PIO exports and the multiply/divide coprocessor.
// The master drives start level and operands; the slave returns results/status.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             botao;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] produto;
  logic [WIDTH-1:0] quociente;
  logic [WIDTH-1:0] resto;
  logic             busy;
  logic             done;
  logic             ovf;
  logic             div_zero;

  modport master (
    output botao, a, b,
    input  produto, quociente, resto, busy, done, ovf, div_zero
  );

  modport slave (
    input  botao, a, b,
    output produto, quociente, resto, busy, done, ovf, div_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Sequential unsigned multiply/divide coprocessor.
// One shift-add multiply step and one restoring divide step per clock; the
// results land in output registers in a single WRITE cycle and hold until the
// next operation completes.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  mul_div_unit_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

  state_t             state_q, state_d;
  logic               botao_q, botao_d;
  logic [WIDTH-1:0]   a_r_q, a_r_d;
  logic [WIDTH-1:0]   b_r_q, b_r_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  // The stored partial remainder is always below B_r, so its extra bit is
  // only materialised in the shifted value used for the compare/subtract.
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   produto_q, produto_d;
  logic [WIDTH-1:0]   quociente_q, quociente_d;
  logic [WIDTH-1:0]   resto_q, resto_d;
  logic               ovf_q, ovf_d;
  logic               div_zero_q, div_zero_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               start;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     r_shift;
  logic [WIDTH:0]     r_sub;

  // Next-state, datapath step and output-load logic.
  always_comb begin
    state_d     = state_q;
    botao_d     = bus.botao;
    a_r_d       = a_r_q;
    b_r_d       = b_r_q;
    p_d         = p_q;
    m_d         = m_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    produto_d   = produto_q;
    quociente_d = quociente_q;
    resto_d     = resto_q;
    ovf_d       = ovf_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;
    busy_d      = busy_q;

    start   = bus.botao & ~botao_q;
    mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (m_q[0] ? {1'b0, a_r_q} : '0);
    r_shift = {r_q, q_q[WIDTH-1]};
    r_sub   = r_shift - {1'b0, b_r_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_r_d   = bus.a;
          b_r_d   = bus.b;
          p_d     = '0;
          m_d     = bus.b;
          r_d     = '0;
          q_d     = bus.a;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        p_d = {mul_sum, p_q[WIDTH-1:1]};
        m_d = m_q >> 1;
        if (r_shift >= {1'b0, b_r_q}) begin
          r_d = r_sub[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_shift[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        produto_d   = p_q[WIDTH-1:0];
        ovf_d       = |p_q[2*WIDTH-1:WIDTH];
        quociente_d = q_q;
        resto_d     = r_q;
        div_zero_d  = (b_r_q == '0);
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      botao_q     <= 1'b0;
      a_r_q       <= '0;
      b_r_q       <= '0;
      p_q         <= '0;
      m_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      produto_q   <= '0;
      quociente_q <= '0;
      resto_q     <= '0;
      ovf_q       <= 1'b0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      botao_q     <= botao_d;
      a_r_q       <= a_r_d;
      b_r_q       <= b_r_d;
      p_q         <= p_d;
      m_q         <= m_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      produto_q   <= produto_d;
      quociente_q <= quociente_d;
      resto_q     <= resto_d;
      ovf_q       <= ovf_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.produto   = produto_q;
  assign bus.quociente = quociente_q;
  assign bus.resto     = resto_q;
  assign bus.ovf       = ovf_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: cycle-level arithmetic model plus
// directed scenarios with literal expectations, then randomized stimulus.
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Reference model: an operation accepted at a start edge finishes W+1
  // edges later, with results from plain arithmetic.
  logic         m_prev = 1'b0;
  int           m_rem = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [W-1:0] e_prod = '0, e_quo = '0, e_res = '0;
  logic         e_ovf = 1'b0, e_dz = 1'b0, e_done = 1'b0;
  logic [2*W-1:0] m_full;

  assign m_full = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev <= 1'b0; m_rem <= 0; m_a <= '0; m_b <= '0;
      e_prod <= '0; e_quo <= '0; e_res <= '0;
      e_ovf <= 1'b0; e_dz <= 1'b0; e_done <= 1'b0;
    end else begin
      e_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          e_prod <= m_full[W-1:0];
          e_ovf  <= |m_full[2*W-1:W];
          e_quo  <= (m_b == '0) ? '1 : m_a / m_b;
          e_res  <= (m_b == '0) ? m_a : m_a % m_b;
          e_dz   <= (m_b == '0);
          e_done <= 1'b1;
        end
      end else if (bus.botao && !m_prev) begin
        m_a   <= bus.a;
        m_b   <= bus.b;
        m_rem <= W + 1;
      end
      m_prev <= bus.botao;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("produto",   bus.produto,   e_prod);
      chk("quociente", bus.quociente, e_quo);
      chk("resto",     bus.resto,     e_res);
      chk("ovf",       W'(bus.ovf),      W'(e_ovf));
      chk("div_zero",  W'(bus.div_zero), W'(e_dz));
      chk("done",      W'(bus.done),     W'(e_done));
      chk("busy",      W'(bus.busy),     W'(m_rem > 0));
      if (bus.done === 1'b1) done_seen++;
    end
  end

  // Waits (bounded) for done; returns at the negedge where done is high.
  task automatic wait_done(inout int lat);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done === 1'b1) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", W'(0), W'(1));
  endtask

  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input bit hold, output int lat);
    @(posedge clk);
    #1 bus.a = ai; bus.b = bi; bus.botao = 1'b1;
    @(posedge clk);   // start edge sampled here
    lat = 1;
    #1 if (!hold) bus.botao = 1'b0;
    wait_done(lat);
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'($urandom_range(0, 15));
      2: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  int lat;
  int d0;

  initial begin
    bus.botao = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_produto",   bus.produto,   W'(0));
    chk("rst_quociente", bus.quociente, W'(0));
    chk("rst_resto",     bus.resto,     W'(0));
    chk("rst_busy",      W'(bus.busy),  W'(0));
    chk("rst_done",      W'(bus.done),  W'(0));

    // 7 x 6, 7 / 6
    d0 = done_seen;
    run_op(32'd7, 32'd6, 1'b0, lat);
    chk("t1_latency", W'(lat), W'(W + 2));
    repeat (3) @(posedge clk);
    #1;
    chk("t1_produto",   bus.produto,   32'd42);
    chk("t1_quociente", bus.quociente, 32'd1);
    chk("t1_resto",     bus.resto,     32'd1);
    chk("t1_ovf",       W'(bus.ovf),      W'(0));
    chk("t1_div_zero",  W'(bus.div_zero), W'(0));
    chk("t1_done_pulses", W'(done_seen - d0), W'(1));

    // 100 / 7 with the button held afterwards
    d0 = done_seen;
    run_op(32'd100, 32'd7, 1'b1, lat);
    repeat (6) @(posedge clk);
    #1;
    chk("t2_no_retrigger_busy", W'(bus.busy), W'(0));
    chk("t2_done_pulses", W'(done_seen - d0), W'(1));
    chk("t2_produto",   bus.produto,   32'd700);
    chk("t2_quociente", bus.quociente, 32'd14);
    chk("t2_resto",     bus.resto,     32'd2);
    bus.botao = 1'b0;

    // Product overflow
    run_op(32'hFFFF_FFFF, 32'd2, 1'b0, lat);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_produto",   bus.produto,   32'hFFFF_FFFE);
    chk("t3_ovf",       W'(bus.ovf),   W'(1));
    chk("t3_quociente", bus.quociente, 32'h7FFF_FFFF);
    chk("t3_resto",     bus.resto,     32'd1);

    // Divide by zero
    run_op(32'd12345, 32'd0, 1'b0, lat);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_quociente", bus.quociente, 32'hFFFF_FFFF);
    chk("t4_resto",     bus.resto,     32'd12345);
    chk("t4_produto",   bus.produto,   32'd0);
    chk("t4_div_zero",  W'(bus.div_zero), W'(1));

    // Second edge and operand change while busy are ignored
    d0 = done_seen;
    @(posedge clk);
    #1 bus.a = 32'd9; bus.b = 32'd3; bus.botao = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 bus.botao = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.botao = 1'b1; bus.a = 32'd1000; bus.b = 32'd1;
    @(posedge clk);
    #1 bus.botao = 1'b0;
    lat = lat + 11;
    wait_done(lat);
    repeat (50) @(posedge clk);
    #1;
    chk("t5_produto",   bus.produto,   32'd27);
    chk("t5_quociente", bus.quociente, 32'd3);
    chk("t5_resto",     bus.resto,     32'd0);
    chk("t5_done_pulses", W'(done_seen - d0), W'(1));

    // Reset in the middle of an operation
    @(posedge clk);
    #1 bus.a = 32'hABCD; bus.b = 32'h12; bus.botao = 1'b1;
    @(posedge clk);
    #1 bus.botao = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_produto",   bus.produto,   W'(0));
    chk("t6_rst_quociente", bus.quociente, W'(0));
    chk("t6_rst_resto",     bus.resto,     W'(0));
    chk("t6_rst_busy",      W'(bus.busy),     W'(0));
    chk("t6_rst_done",      W'(bus.done),     W'(0));
    chk("t6_rst_div_zero",  W'(bus.div_zero), W'(0));
    chk("t6_rst_ovf",       W'(bus.ovf),      W'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(32'd5, 32'd5, 1'b0, lat);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_produto",   bus.produto,   32'd25);
    chk("t6_quociente", bus.quociente, 32'd1);
    chk("t6_resto",     bus.resto,     32'd0);

    // Randomized button/operand activity with occasional async resets
    d0 = done_seen;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) bus.botao = ~bus.botao;
      if ($urandom_range(0, 7) == 0) begin
        bus.a = rand_op();
        bus.b = rand_op();
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    chk("rand_ops_completed", W'(done_seen - d0 > 20), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
